// File: rtl/cgra_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
// Shared definitions for the single-PE CGRA:
//   WIDTH              datapath width (also the track count per side)
//   CFG_OPA..CFG_OUT   configuration register addresses
//   sel_e              operand select encoding (3 bits)
//   op_e               ALU operation encoding (4 bits)
// -----------------------------------------------------------------------------
package cgra_pkg;

    localparam int WIDTH = 16;

    localparam logic [31:0] CFG_OPA   = 32'h0000_0001;
    localparam logic [31:0] CFG_OPB   = 32'h0000_0002;
    localparam logic [31:0] CFG_CONST = 32'h0000_0003;
    localparam logic [31:0] CFG_OP    = 32'h0000_0004;
    localparam logic [31:0] CFG_OUT   = 32'h0000_0005;

    // Codes 6 and 7 both select a zero operand.
    typedef enum logic [2:0] {
        SEL_IN0   = 3'd0,
        SEL_IN1   = 3'd1,
        SEL_IN2   = 3'd2,
        SEL_IN3   = 3'd3,
        SEL_CONST = 3'd4,
        SEL_RES   = 3'd5,
        SEL_ZERO6 = 3'd6,
        SEL_ZERO7 = 3'd7
    } sel_e;

    // Codes 9..15 are not listed here; the ALU yields zero for them.
    typedef enum logic [3:0] {
        OP_PASSA = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_SHL   = 4'd4,
        OP_LSHR  = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_XOR   = 4'd8
    } op_e;

endpackage

// File: rtl/cgra_if.sv
// -----------------------------------------------------------------------------
// cgra_if
// Bundle between the CGRA top (pad packing + config registers) and the PE.
//   in_bus     four WIDTH-bit input buses, one per side
//   opa_sel    operand A select
//   opb_sel    operand B select
//   const_val  constant operand
//   op         ALU operation
//   out_cfg    bit0 output enable, bit1 registered(1)/combinational(0)
//   out_bus    PE result towards the side-0 output pads
// master: drives configuration and inputs, receives out_bus (top side)
// slave : consumes configuration and inputs, drives out_bus (PE side)
// -----------------------------------------------------------------------------
interface cgra_if;
    import cgra_pkg::*;

    logic [3:0][WIDTH-1:0] in_bus;
    sel_e                  opa_sel;
    sel_e                  opb_sel;
    logic [WIDTH-1:0]      const_val;
    op_e                   op;
    logic [1:0]            out_cfg;
    logic [WIDTH-1:0]      out_bus;

    modport master (
        output in_bus,
        output opa_sel,
        output opb_sel,
        output const_val,
        output op,
        output out_cfg,
        input  out_bus
    );

    modport slave (
        input  in_bus,
        input  opa_sel,
        input  opb_sel,
        input  const_val,
        input  op,
        input  out_cfg,
        output out_bus
    );

endinterface

// File: rtl/cgra_pe.sv
// -----------------------------------------------------------------------------
// cgra_pe
// Single processing element: two operand muxes, a 16-bit unsigned ALU,
// the res_q result register and the output mux.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears res_q)
//   bus    cgra_if slave: inputs/configuration in, out_bus out
// -----------------------------------------------------------------------------
module cgra_pe
    import cgra_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    cgra_if.slave bus
);

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] res_q;

    function automatic logic [WIDTH-1:0] pick_operand(
        input sel_e                  sel,
        input logic [3:0][WIDTH-1:0] in_bus,
        input logic [WIDTH-1:0]      const_val,
        input logic [WIDTH-1:0]      res_val
    );
        logic [WIDTH-1:0] val;
        case (sel)
            SEL_IN0:   val = in_bus[0];
            SEL_IN1:   val = in_bus[1];
            SEL_IN2:   val = in_bus[2];
            SEL_IN3:   val = in_bus[3];
            SEL_CONST: val = const_val;
            SEL_RES:   val = res_val;
            default:   val = '0;
        endcase
        return val;
    endfunction

    // Feedback uses res_q (a register), so selecting it never closes a
    // combinational loop even in combinational output mode.
    always_comb begin
        opa = pick_operand(bus.opa_sel, bus.in_bus, bus.const_val, res_q);
        opb = pick_operand(bus.opb_sel, bus.in_bus, bus.const_val, res_q);
    end

    // All arithmetic is modulo 2^WIDTH; the multiply keeps the low half.
    always_comb begin
        alu_result = '0;
        case (bus.op)
            OP_PASSA: alu_result = opa;
            OP_ADD:   alu_result = opa + opb;
            OP_SUB:   alu_result = opa - opb;
            OP_MUL:   alu_result = opa * opb;
            OP_SHL:   alu_result = opa << opb[3:0];
            OP_LSHR:  alu_result = opa >> opb[3:0];
            OP_AND:   alu_result = opa & opb;
            OP_OR:    alu_result = opa | opb;
            OP_XOR:   alu_result = opa ^ opb;
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= alu_result;
        end
    end

    assign bus.out_bus = bus.out_cfg[0] ? (bus.out_cfg[1] ? res_q : alu_result)
                                        : '0;

endmodule

// File: rtl/cgra_top.sv
// -----------------------------------------------------------------------------
// cgra_top
// Minimal single-PE CGRA configured through a flat address/data port.
// Ports:
//   clk_in                 sole clock, rising edge
//   reset_in               asynchronous active-low reset
//   config_addr_in         config register address (0 and unknown = no-op)
//   config_data_in         config write data
//   pad_S<s>_T<t>_in       64 input pads; side s forms in_bus[s], T0 = MSB
//   pad_S0_T<t>_out        16 output pads; T0 = out_bus MSB
//   tdi, tms, tck, trst_n  JTAG inputs, unused
//   tdo                    JTAG output, constant 0
// This level holds pad packing, config decode/registers, output unpacking
// and the tdo tie-off; the datapath lives in cgra_pe.
// -----------------------------------------------------------------------------
module cgra_top
    import cgra_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] config_addr_in,
    input  logic [DATA_W-1:0] config_data_in,
    input  logic pad_S0_T0_in,  input  logic pad_S0_T1_in,  input  logic pad_S0_T2_in,  input  logic pad_S0_T3_in,
    input  logic pad_S0_T4_in,  input  logic pad_S0_T5_in,  input  logic pad_S0_T6_in,  input  logic pad_S0_T7_in,
    input  logic pad_S0_T8_in,  input  logic pad_S0_T9_in,  input  logic pad_S0_T10_in, input  logic pad_S0_T11_in,
    input  logic pad_S0_T12_in, input  logic pad_S0_T13_in, input  logic pad_S0_T14_in, input  logic pad_S0_T15_in,
    input  logic pad_S1_T0_in,  input  logic pad_S1_T1_in,  input  logic pad_S1_T2_in,  input  logic pad_S1_T3_in,
    input  logic pad_S1_T4_in,  input  logic pad_S1_T5_in,  input  logic pad_S1_T6_in,  input  logic pad_S1_T7_in,
    input  logic pad_S1_T8_in,  input  logic pad_S1_T9_in,  input  logic pad_S1_T10_in, input  logic pad_S1_T11_in,
    input  logic pad_S1_T12_in, input  logic pad_S1_T13_in, input  logic pad_S1_T14_in, input  logic pad_S1_T15_in,
    input  logic pad_S2_T0_in,  input  logic pad_S2_T1_in,  input  logic pad_S2_T2_in,  input  logic pad_S2_T3_in,
    input  logic pad_S2_T4_in,  input  logic pad_S2_T5_in,  input  logic pad_S2_T6_in,  input  logic pad_S2_T7_in,
    input  logic pad_S2_T8_in,  input  logic pad_S2_T9_in,  input  logic pad_S2_T10_in, input  logic pad_S2_T11_in,
    input  logic pad_S2_T12_in, input  logic pad_S2_T13_in, input  logic pad_S2_T14_in, input  logic pad_S2_T15_in,
    input  logic pad_S3_T0_in,  input  logic pad_S3_T1_in,  input  logic pad_S3_T2_in,  input  logic pad_S3_T3_in,
    input  logic pad_S3_T4_in,  input  logic pad_S3_T5_in,  input  logic pad_S3_T6_in,  input  logic pad_S3_T7_in,
    input  logic pad_S3_T8_in,  input  logic pad_S3_T9_in,  input  logic pad_S3_T10_in, input  logic pad_S3_T11_in,
    input  logic pad_S3_T12_in, input  logic pad_S3_T13_in, input  logic pad_S3_T14_in, input  logic pad_S3_T15_in,
    output logic pad_S0_T0_out,  output logic pad_S0_T1_out,  output logic pad_S0_T2_out,  output logic pad_S0_T3_out,
    output logic pad_S0_T4_out,  output logic pad_S0_T5_out,  output logic pad_S0_T6_out,  output logic pad_S0_T7_out,
    output logic pad_S0_T8_out,  output logic pad_S0_T9_out,  output logic pad_S0_T10_out, output logic pad_S0_T11_out,
    output logic pad_S0_T12_out, output logic pad_S0_T13_out, output logic pad_S0_T14_out, output logic pad_S0_T15_out,
    input  logic tdi,
    input  logic tms,
    input  logic tck,
    input  logic trst_n,
    output logic tdo
);

    cgra_if pe_bus ();

    sel_e             opa_sel_reg;
    sel_e             opb_sel_reg;
    logic [WIDTH-1:0] const_reg;
    op_e              op_reg;
    logic [1:0]       out_cfg_reg;

    // Pad T0 is the MSB of each bus.
    assign pe_bus.in_bus[0] = {pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
                               pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
                               pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
                               pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
    assign pe_bus.in_bus[1] = {pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
                               pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
                               pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
                               pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
    assign pe_bus.in_bus[2] = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
                               pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
                               pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
                               pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
    assign pe_bus.in_bus[3] = {pad_S3_T0_in,  pad_S3_T1_in,  pad_S3_T2_in,  pad_S3_T3_in,
                               pad_S3_T4_in,  pad_S3_T5_in,  pad_S3_T6_in,  pad_S3_T7_in,
                               pad_S3_T8_in,  pad_S3_T9_in,  pad_S3_T10_in, pad_S3_T11_in,
                               pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

    // Config decode: any edge with a matching address loads the register;
    // all other addresses, including 0, leave the configuration untouched.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            opa_sel_reg <= SEL_IN0;
            opb_sel_reg <= SEL_IN0;
            const_reg   <= '0;
            op_reg      <= OP_PASSA;
            out_cfg_reg <= 2'b00;
        end else begin
            case (config_addr_in)
                CFG_OPA:   opa_sel_reg <= sel_e'(config_data_in[2:0]);
                CFG_OPB:   opb_sel_reg <= sel_e'(config_data_in[2:0]);
                CFG_CONST: const_reg   <= config_data_in[WIDTH-1:0];
                CFG_OP:    op_reg      <= op_e'(config_data_in[3:0]);
                CFG_OUT:   out_cfg_reg <= config_data_in[1:0];
                default:   ;
            endcase
        end
    end

    assign pe_bus.opa_sel   = opa_sel_reg;
    assign pe_bus.opb_sel   = opb_sel_reg;
    assign pe_bus.const_val = const_reg;
    assign pe_bus.op        = op_reg;
    assign pe_bus.out_cfg   = out_cfg_reg;

    cgra_pe u_pe (
        .clk   (clk_in),
        .rst_n (reset_in),
        .bus   (pe_bus)
    );

    assign pad_S0_T0_out  = pe_bus.out_bus[15];
    assign pad_S0_T1_out  = pe_bus.out_bus[14];
    assign pad_S0_T2_out  = pe_bus.out_bus[13];
    assign pad_S0_T3_out  = pe_bus.out_bus[12];
    assign pad_S0_T4_out  = pe_bus.out_bus[11];
    assign pad_S0_T5_out  = pe_bus.out_bus[10];
    assign pad_S0_T6_out  = pe_bus.out_bus[9];
    assign pad_S0_T7_out  = pe_bus.out_bus[8];
    assign pad_S0_T8_out  = pe_bus.out_bus[7];
    assign pad_S0_T9_out  = pe_bus.out_bus[6];
    assign pad_S0_T10_out = pe_bus.out_bus[5];
    assign pad_S0_T11_out = pe_bus.out_bus[4];
    assign pad_S0_T12_out = pe_bus.out_bus[3];
    assign pad_S0_T13_out = pe_bus.out_bus[2];
    assign pad_S0_T14_out = pe_bus.out_bus[1];
    assign pad_S0_T15_out = pe_bus.out_bus[0];

    // JTAG is unused; its inputs and the upper config data bits are
    // intentionally ignored.
    assign tdo = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{tdi, tms, tck, trst_n, config_data_in[DATA_W-1:WIDTH]};

endmodule

// File: tb/tb_cgra_top.sv
// -----------------------------------------------------------------------------
// tb_cgra_top
// Directed, self-checking bench for cgra_top. Input buses and the observed
// output bus live in a cgra_if instance; its config fields shadow the last
// value written to each config register for the transaction log.
// -----------------------------------------------------------------------------
module tb_cgra_top;
    import cgra_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        tdi, tms, tck, trst_n;
    logic        tdo;

    int n_checks;
    int n_fail;

    cgra_if bus ();

    cgra_top dut (
        .clk_in         (clk),
        .reset_in       (reset_n),
        .config_addr_in (config_addr),
        .config_data_in (config_data),
        .pad_S0_T0_in (bus.in_bus[0][15]), .pad_S0_T1_in (bus.in_bus[0][14]), .pad_S0_T2_in (bus.in_bus[0][13]), .pad_S0_T3_in (bus.in_bus[0][12]),
        .pad_S0_T4_in (bus.in_bus[0][11]), .pad_S0_T5_in (bus.in_bus[0][10]), .pad_S0_T6_in (bus.in_bus[0][9]),  .pad_S0_T7_in (bus.in_bus[0][8]),
        .pad_S0_T8_in (bus.in_bus[0][7]),  .pad_S0_T9_in (bus.in_bus[0][6]),  .pad_S0_T10_in(bus.in_bus[0][5]),  .pad_S0_T11_in(bus.in_bus[0][4]),
        .pad_S0_T12_in(bus.in_bus[0][3]),  .pad_S0_T13_in(bus.in_bus[0][2]),  .pad_S0_T14_in(bus.in_bus[0][1]),  .pad_S0_T15_in(bus.in_bus[0][0]),
        .pad_S1_T0_in (bus.in_bus[1][15]), .pad_S1_T1_in (bus.in_bus[1][14]), .pad_S1_T2_in (bus.in_bus[1][13]), .pad_S1_T3_in (bus.in_bus[1][12]),
        .pad_S1_T4_in (bus.in_bus[1][11]), .pad_S1_T5_in (bus.in_bus[1][10]), .pad_S1_T6_in (bus.in_bus[1][9]),  .pad_S1_T7_in (bus.in_bus[1][8]),
        .pad_S1_T8_in (bus.in_bus[1][7]),  .pad_S1_T9_in (bus.in_bus[1][6]),  .pad_S1_T10_in(bus.in_bus[1][5]),  .pad_S1_T11_in(bus.in_bus[1][4]),
        .pad_S1_T12_in(bus.in_bus[1][3]),  .pad_S1_T13_in(bus.in_bus[1][2]),  .pad_S1_T14_in(bus.in_bus[1][1]),  .pad_S1_T15_in(bus.in_bus[1][0]),
        .pad_S2_T0_in (bus.in_bus[2][15]), .pad_S2_T1_in (bus.in_bus[2][14]), .pad_S2_T2_in (bus.in_bus[2][13]), .pad_S2_T3_in (bus.in_bus[2][12]),
        .pad_S2_T4_in (bus.in_bus[2][11]), .pad_S2_T5_in (bus.in_bus[2][10]), .pad_S2_T6_in (bus.in_bus[2][9]),  .pad_S2_T7_in (bus.in_bus[2][8]),
        .pad_S2_T8_in (bus.in_bus[2][7]),  .pad_S2_T9_in (bus.in_bus[2][6]),  .pad_S2_T10_in(bus.in_bus[2][5]),  .pad_S2_T11_in(bus.in_bus[2][4]),
        .pad_S2_T12_in(bus.in_bus[2][3]),  .pad_S2_T13_in(bus.in_bus[2][2]),  .pad_S2_T14_in(bus.in_bus[2][1]),  .pad_S2_T15_in(bus.in_bus[2][0]),
        .pad_S3_T0_in (bus.in_bus[3][15]), .pad_S3_T1_in (bus.in_bus[3][14]), .pad_S3_T2_in (bus.in_bus[3][13]), .pad_S3_T3_in (bus.in_bus[3][12]),
        .pad_S3_T4_in (bus.in_bus[3][11]), .pad_S3_T5_in (bus.in_bus[3][10]), .pad_S3_T6_in (bus.in_bus[3][9]),  .pad_S3_T7_in (bus.in_bus[3][8]),
        .pad_S3_T8_in (bus.in_bus[3][7]),  .pad_S3_T9_in (bus.in_bus[3][6]),  .pad_S3_T10_in(bus.in_bus[3][5]),  .pad_S3_T11_in(bus.in_bus[3][4]),
        .pad_S3_T12_in(bus.in_bus[3][3]),  .pad_S3_T13_in(bus.in_bus[3][2]),  .pad_S3_T14_in(bus.in_bus[3][1]),  .pad_S3_T15_in(bus.in_bus[3][0]),
        .pad_S0_T0_out (bus.out_bus[15]), .pad_S0_T1_out (bus.out_bus[14]), .pad_S0_T2_out (bus.out_bus[13]), .pad_S0_T3_out (bus.out_bus[12]),
        .pad_S0_T4_out (bus.out_bus[11]), .pad_S0_T5_out (bus.out_bus[10]), .pad_S0_T6_out (bus.out_bus[9]),  .pad_S0_T7_out (bus.out_bus[8]),
        .pad_S0_T8_out (bus.out_bus[7]),  .pad_S0_T9_out (bus.out_bus[6]),  .pad_S0_T10_out(bus.out_bus[5]),  .pad_S0_T11_out(bus.out_bus[4]),
        .pad_S0_T12_out(bus.out_bus[3]),  .pad_S0_T13_out(bus.out_bus[2]),  .pad_S0_T14_out(bus.out_bus[1]),  .pad_S0_T15_out(bus.out_bus[0]),
        .tdi    (tdi),
        .tms    (tms),
        .tck    (tck),
        .trst_n (trst_n),
        .tdo    (tdo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One config write: drive on the falling edge, captured on the next
    // rising edge, address returned to 0 just after.
    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        config_addr = addr;
        config_data = data;
        case (addr)
            32'h1: bus.opa_sel   = sel_e'(data[2:0]);
            32'h2: bus.opb_sel   = sel_e'(data[2:0]);
            32'h3: bus.const_val = data[15:0];
            32'h4: bus.op        = op_e'(data[3:0]);
            32'h5: bus.out_cfg   = data[1:0];
            default: ;
        endcase
        @(posedge clk);
        #1;
        config_addr = 32'h0;
        config_data = 32'h0;
        $display("cfg   t=%0t addr=%0h data=%h | opa=%0d opb=%0d const=%h op=%0d out_cfg=%0d out_bus=%h",
                 $time, addr, data, bus.opa_sel, bus.opb_sel, bus.const_val, bus.op, bus.out_cfg, bus.out_bus);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        config_addr = 32'h0;
        config_data = 32'h0;
        tdi = 1'b0; tms = 1'b0; tck = 1'b0; trst_n = 1'b1;
        bus.in_bus    = '0;
        bus.in_bus[2] = 16'd3;
        bus.opa_sel   = SEL_IN0;
        bus.opb_sel   = SEL_IN0;
        bus.const_val = '0;
        bus.op        = OP_PASSA;
        bus.out_cfg   = 2'b00;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'h0000) begin
            $display("FAIL reset_assert_out: got %h expected 0000", bus.out_bus);
            n_fail++;
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_bus !== 16'h0000 || tdo !== 1'b0) begin
                $display("FAIL reset_idle cycle %0d: out=%h tdo=%b expected 0000/0", i, bus.out_bus, tdo);
                n_fail++;
            end
        end
        $display("reset t=%0t idle 100 cycles out_bus=%h tdo=%b", $time, bus.out_bus, tdo);
    endtask

    task automatic test_pow2();
        @(negedge clk);
        bus.in_bus[2] = 16'd0;
        cfg_write(32'h1, 32'd2);
        cfg_write(32'h2, 32'd4);
        cfg_write(32'h3, 32'd2);
        cfg_write(32'h4, 32'd3);
        cfg_write(32'h5, 32'd3);
        @(negedge clk);
        bus.in_bus[2] = 16'd3;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'd0) begin
            $display("FAIL pow2_before_edge: got %h expected 0000", bus.out_bus);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_bus !== 16'd6) begin
            $display("FAIL pow2_after_edge: got %h expected 0006", bus.out_bus);
            n_fail++;
        end
        repeat (995) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_bus !== 16'd6) begin
            $display("FAIL pow2_hold: got %h expected 0006", bus.out_bus);
            n_fail++;
        end
        $display("pow2  t=%0t in2=%h out_bus=%h", $time, bus.in_bus[2], bus.out_bus);
    endtask

    task automatic test_comb();
        cfg_write(32'h5, 32'd1);
        n_checks++;
        if (bus.out_bus !== 16'd6) begin
            $display("FAIL comb_initial: got %h expected 0006", bus.out_bus);
            n_fail++;
        end
        @(negedge clk);
        #1;
        bus.in_bus[2] = 16'd7;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'd14) begin
            $display("FAIL comb_no_edge: got %h expected 000e", bus.out_bus);
            n_fail++;
        end
        $display("comb  t=%0t in2=%h out_bus=%h", $time, bus.in_bus[2], bus.out_bus);
    endtask

    task automatic test_ops();
        logic [3:0]  op_tab  [12] = '{4'd1, 4'd3, 4'd2, 4'd3, 4'd4, 4'd5,
                                      4'd6, 4'd7, 4'd8, 4'd0, 4'd9, 4'd15};
        logic [15:0] a_tab   [12] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0123, 16'h0001, 16'h8000,
                                      16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hBEEF, 16'h1234, 16'h1234};
        logic [15:0] b_tab   [12] = '{16'h0002, 16'h0002, 16'h0002, 16'h0010, 16'h0013, 16'h001F,
                                      16'hFF00, 16'hFF00, 16'hFF00, 16'h0000, 16'h0001, 16'h0001};
        logic [15:0] exp_tab [12] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h1230, 16'h0008, 16'h0001,
                                      16'hF000, 16'hFFF0, 16'h0FF0, 16'hBEEF, 16'h0000, 16'h0000};
        cfg_write(32'h1, 32'd4);
        cfg_write(32'h2, 32'd1);
        cfg_write(32'h5, 32'd1);
        for (int i = 0; i < 12; i++) begin
            cfg_write(32'h3, {16'h0, a_tab[i]});
            cfg_write(32'h4, {28'h0, op_tab[i]});
            bus.in_bus[1] = b_tab[i];
            #1;
            n_checks++;
            if (bus.out_bus !== exp_tab[i]) begin
                $display("FAIL op%0d a=%h b=%h: got %h expected %h",
                         op_tab[i], a_tab[i], b_tab[i], bus.out_bus, exp_tab[i]);
                n_fail++;
            end
            $display("op    t=%0t op=%0d a=%h b=%h out_bus=%h", $time, op_tab[i], a_tab[i], b_tab[i], bus.out_bus);
        end
    endtask

    task automatic test_sel();
        logic [15:0] exp_tab [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                     16'h5555, 16'h5555, 16'h0000, 16'h0000};
        bus.in_bus[0] = 16'h1111;
        bus.in_bus[1] = 16'h2222;
        bus.in_bus[2] = 16'h3333;
        bus.in_bus[3] = 16'h4444;
        cfg_write(32'h3, 32'h5555);
        cfg_write(32'h4, 32'd0);
        // Sel 5 sees res_q, which the write edge loaded with passA(CONST).
        for (int s = 0; s < 8; s++) begin
            cfg_write(32'h1, s);
            n_checks++;
            if (bus.out_bus !== exp_tab[s]) begin
                $display("FAIL sel%0d: got %h expected %h", s, bus.out_bus, exp_tab[s]);
                n_fail++;
            end
        end
    endtask

    task automatic test_bit_order();
        cfg_write(32'h1, 32'd2);
        cfg_write(32'h4, 32'd0);
        bus.in_bus    = '0;
        bus.in_bus[2] = 16'h8000;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'h8000) begin
            $display("FAIL bit_order_T0: got %h expected 8000", bus.out_bus);
            n_fail++;
        end
        bus.in_bus[2] = 16'h0001;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'h0001) begin
            $display("FAIL bit_order_T15: got %h expected 0001", bus.out_bus);
            n_fail++;
        end
        $display("bits  t=%0t in2=%h out_bus=%h", $time, bus.in_bus[2], bus.out_bus);
    endtask

    task automatic test_accum();
        @(negedge clk);
        reset_n = 1'b0;
        bus.in_bus = '0;
        @(negedge clk);
        reset_n = 1'b1;
        cfg_write(32'h1, 32'd5);
        cfg_write(32'h2, 32'd4);
        cfg_write(32'h3, 32'd1);
        cfg_write(32'h4, 32'd1);
        cfg_write(32'h5, 32'd3);
        n_checks++;
        if (bus.out_bus !== 16'd1) begin
            $display("FAIL accum_count1: got %h expected 0001", bus.out_bus);
            n_fail++;
        end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_bus !== 16'(k)) begin
                $display("FAIL accum_count%0d: got %h expected %h", k, bus.out_bus, 16'(k));
                n_fail++;
            end
            $display("accum t=%0t out_bus=%h", $time, bus.out_bus);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_bus !== 16'h0000) begin
            $display("FAIL accum_async_reset: got %h expected 0000", bus.out_bus);
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.in_bus[0] = 16'h55AA;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_bus !== 16'h0000) begin
            $display("FAIL accum_idle_after_reset: got %h expected 0000", bus.out_bus);
            n_fail++;
        end
        // Only output enable is rewritten: passA of in_bus[0] proves the
        // select and op registers were cleared by the reset.
        cfg_write(32'h5, 32'd1);
        n_checks++;
        if (bus.out_bus !== 16'h55AA) begin
            $display("FAIL accum_config_cleared: got %h expected 55aa", bus.out_bus);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pow2();
        test_comb();
        test_ops();
        test_sel();
        test_bit_order();
        test_accum();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
